// File: rtl/switch_reader_pkg.sv
// Shared constants and helpers for the switch/button reader peripheral.
package switch_reader_pkg;

    localparam logic [1:0]  SR_OFF_SW    = 2'd0;
    localparam logic [1:0]  SR_OFF_BTN   = 2'd1;
    localparam logic [1:0]  SR_OFF_PRESS = 2'd2;
    localparam int unsigned SR_WINDOW    = 3;

    // Bits needed to hold values 0..value-1 (at least 1 for value>=2).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < {1'b0, value}) begin
                result = 32'(i) + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_reader_if.sv
// System bus segment shared with the display peripherals.
interface switch_reader_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (output enable, rw, addr, data_in, input data_out, ack);
    modport slave  (input enable, rw, addr, data_in, output data_out, ack);
endinterface

// File: rtl/switch_reader_debounce_bit.sv
// One input: 2-flop synchronizer, stability counter and debounced-rise pulse.
module debounce_bit
    import switch_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned   CW      = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Synchronizer flops for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Next level/count: any sample agreeing with the level restarts the count.
    always_comb begin
        level_s = level_r;
        cnt_s   = cnt_r;
        if (sync2_r == level_r) begin
            cnt_s = '0;
        end else if (cnt_r == CNT_MAX) begin
            level_s = sync2_r;
            cnt_s   = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // Debounced level and counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            level_r <= level_s;
            cnt_r   <= cnt_s;
        end
    end

    assign level = level_r;
    assign rise  = level_s & ~level_r;

endmodule

// File: rtl/switch_reader.sv
// Memory-mapped reader for debounced switches/buttons with sticky W1C press flags.
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter logic [31:0] BASE            = 32'd32,
    parameter int unsigned NSW             = 8,
    parameter int unsigned NBTN            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSW-1:0]   sw,
    input  logic [NBTN-1:0]  btn,
    switch_reader_if.slave   bus
);
    localparam int unsigned NIN = NSW + NBTN;

    logic [NIN-1:0]  raw_s;
    logic [NIN-1:0]  level_s;
    logic [NIN-1:0]  rise_s;
    logic [31:0]     offset_s;
    logic            in_range_s;
    logic            read_s;
    logic            clr_s;
    logic [NBTN-1:0] clr_mask_s;
    logic [NBTN-1:0] flags_r;
    logic [NBTN-1:0] flags_s;
    logic [31:0]     rd_data_s;
    logic [31:0]     data_out_r;
    logic            ack_r;
    logic            unused_bits_s;

    assign raw_s = {btn, sw};

    for (genvar g = 0; g < NIN; g++) begin : g_deb
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_s[g]),
            .level (level_s[g]),
            .rise  (rise_s[g])
        );
    end

    // Subtract first so BASE near the top of the address space cannot overflow.
    assign offset_s   = bus.addr - BASE;
    assign in_range_s = bus.enable && (bus.addr >= BASE) && (offset_s < 32'(SR_WINDOW));
    assign read_s     = in_range_s && !bus.rw;
    assign clr_s      = in_range_s && bus.rw && (offset_s[1:0] == SR_OFF_PRESS);
    assign unused_bits_s = ^{bus.data_in, offset_s};

    // Read mux with zero-extended fields.
    always_comb begin
        rd_data_s = 32'd0;
        case (offset_s[1:0])
            SR_OFF_SW:    rd_data_s[NSW-1:0]  = level_s[NSW-1:0];
            SR_OFF_BTN:   rd_data_s[NBTN-1:0] = level_s[NIN-1:NSW];
            SR_OFF_PRESS: rd_data_s[NBTN-1:0] = flags_r;
            default:      rd_data_s = 32'd0;
        endcase
    end

    // Press-flag update: a rise in the same cycle beats a clear.
    always_comb begin
        if (clr_s) begin
            clr_mask_s = bus.data_in[NBTN-1:0];
        end else begin
            clr_mask_s = '0;
        end
        flags_s = (flags_r & ~clr_mask_s) | rise_s[NIN-1:NSW];
    end

    // Sticky flags and registered bus response.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r    <= '0;
            data_out_r <= 32'd0;
            ack_r      <= 1'b0;
        end else begin
            flags_r <= flags_s;
            ack_r   <= read_s;
            if (read_s) begin
                data_out_r <= rd_data_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.ack      = ack_r;

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
- Memory-mapped input peripheral: the read-side counterpart to the board's write-only display drivers.
- Samples board switches and push-buttons through 2-flop synchronizers, then debounces each input.
- Exposes debounced levels and sticky button-press flags on the shared system bus (clk, enable, rw, addr, data).
- Sits on the same bus segment as the display peripherals, at its own address window.

Parameters:
- BASE, 32, first word address of the 3-word register window
- NSW, 8, number of slide switches (1..32)
- NBTN, 4, number of push-buttons (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a debounced level changes (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  bus strobe, one cycle per access
- rw  in  1  1 = write, 0 = read
- addr  in  32  word address
- data_in  in  32  write data
- sw  in  NSW  raw asynchronous switch inputs
- btn  in  NBTN  raw asynchronous button inputs, active-high
- data_out  out  32  read data
- ack  out  1  read data valid

Behaviour:
- One clock (clk); reset is synchronous and active-high, port named reset. All state is cleared on a clk edge with reset=1.
- Reset values: data_out=0, ack=0, all synchronizer flops 0, debounced levels 0, counters 0, press flags 0.
- in_range = enable && addr>=BASE && addr<BASE+3. Offsets:
  - 0 = switch levels [NSW-1:0]
  - 1 = button levels [NBTN-1:0]
  - 2 = press flags [NBTN-1:0]
  - Upper bits read 0.
- Read (in_range, rw=0): data_out and ack are registered on the next clk edge, so latency is 1 cycle. ack is a single-cycle pulse. Out of range or rw=1 gives ack=0 next cycle; data_out holds its last value.
- Write to offset 2 (in_range, rw=1) is write-1-to-clear: flag[i] cleared where data_in[i]=1. Writes to offsets 0/1 are ignored. There is no read-to-clear.
- Synchronizer: 2 flops per input; the debouncer sees raw input delayed by 2 cycles.
- Debounce, per input, state is (level, cnt):
  - synced==level: cnt<=0.
  - synced!=level and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - synced!=level and cnt==DEBOUNCE_CYCLES-1: level<=synced, cnt<=0.
  - Net effect: a change must persist DEBOUNCE_CYCLES cycles. Any glitch shorter than that resets the count and produces no level change.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Press flag: set on a debounced button 0->1 transition (the cycle level rises). Release does not set it.
- Simultaneous set and write-1-to-clear on the same bit in the same cycle: set wins, flag stays 1.
- A read of offset 2 in the same cycle as a set returns the pre-set value; the flag is visible on the next read.
- A read on the same cycle as a level change returns the old level.
- Reset mid-debounce: counters and levels are cleared. An input held high through reset must re-qualify for DEBOUNCE_CYCLES cycles after reset deasserts, and then sets its press flag.
- Back-to-back reads on consecutive cycles are each acked, one per cycle.

Decomposition:
- Shared package/header:
  - register offset constants: SR_OFF_SW=0, SR_OFF_BTN=1, SR_OFF_PRESS=2
  - SR_WINDOW=3
  - clog2 function for counter width
- Sub-module debounce_bit:
  - parameters: DEBOUNCE_CYCLES
  - ports: clk, reset, raw, level, rise
  - contains the 2-flop synchronizer, counter and edge pulse
  - instantiated NSW+NBTN times via generate
- Top level holds the bus decode, press flags and read mux.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, BASE=32.
- Reset with sw=8'hA5 held → reads of addr 32/33/34 return 0 until 2+4 cycles after reset release; then addr 32 reads 32'h000000A5, and ack pulses exactly 1 cycle after each enable.
- btn[0] high for 3 cycles then low (glitch) → button level never changes; addr 34 reads 0.
- btn[2] high for 10 cycles → addr 33 reads 4'b0100 and addr 34 reads 4'b0100. Then write data_in=4 to addr 34 → next read of addr 34 returns 0.
- Debounced rise of btn[1] coincides with a write of data_in=2 to addr 34 → flag[1] remains 1 on the subsequent read.
- Read addr 35 (out of range), and read addr 32 with enable=0 → ack stays 0 and data_out is unchanged. Write to addr 32 → switch level is unchanged.
- Assert reset while btn[3] is mid-count (cnt=2), hold btn[3] high → after release, the flag sets only after 2+4 cycles. Reads on 3 consecutive cycles yield 3 acks.
